// File: rtl/round_controller.sv
// round_controller
//
// Sequences one hangman round. The controller fetches a word from word_ram,
// waits out the RAM read latency and skips empty entries. It latches the word
// and mask, then pulses game_start to arm the game handler. It watches
// game_state for a win or a loss and keeps saturating tallies. Finally it holds
// the result on screen for a fixed time before returning to idle.
//
// Parameters
//   RAM_LATENCY  cycles from a ram_address change until ram_q is valid (1..7)
//   HOLD_CYCLES  result display time in clk cycles (1..2^27-1)
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   start        single-cycle pulse, begins a round
//   abort        single-cycle pulse, cancels the current round
//   auto_mode    0: word chosen by sw_select, 1: sequential next word
//   sw_select    manual word address
//   ram_address  word_ram address
//   ram_q        word_ram data, {word[29:0], mask[25:0]}
//   word         latched word, six 5-bit letters
//   mask         latched letter-set mask
//   word_valid   word/mask hold a checked entry
//   game_start   one-cycle pulse that arms game_handler
//   game_state   from game_handler: 0 idle, 1 playing, 2 won, 3 lost
//   wins         saturating win count
//   losses       saturating loss count
//   round_state  current FSM state encoding
//   busy         FSM in FETCH, CHECK, ARM, PLAY or HOLD
//   error        no non-empty word found
//
// Handshake: start and abort are single-cycle pulses sampled on the rising
// edge. There is no back-pressure. start is accepted only in IDLE or EMPTY.
// abort is accepted in FETCH through HOLD and also in EMPTY. When both arrive
// in IDLE, start wins.

module round_controller #(
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        auto_mode,
    input  logic [3:0]  sw_select,
    output logic [3:0]  ram_address,
    input  logic [55:0] ram_q,
    output logic [29:0] word,
    output logic [25:0] mask,
    output logic        word_valid,
    output logic        game_start,
    input  logic [1:0]  game_state,
    output logic [3:0]  wins,
    output logic [3:0]  losses,
    output logic [2:0]  round_state,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CHECK = 3'd2,
        S_ARM   = 3'd3,
        S_PLAY  = 3'd4,
        S_HOLD  = 3'd5,
        S_EMPTY = 3'd6
    } state_e;

    // Terminal counts. The counters start at 0 on entry, so the last value is N-1.
    localparam logic [2:0]  LAT_LAST  = 3'(RAM_LATENCY - 1);
    localparam logic [26:0] HOLD_LAST = 27'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  addr_q, addr_d;
    logic [3:0]  last_addr_q, last_addr_d;
    logic [3:0]  try_cnt_q, try_cnt_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [26:0] hold_cnt_q, hold_cnt_d;
    logic [29:0] word_q, word_d;
    logic [25:0] mask_q, mask_d;
    logic        word_valid_q, word_valid_d;
    logic        game_start_q, game_start_d;
    logic [3:0]  wins_q, wins_d;
    logic [3:0]  losses_q, losses_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        last_addr_d  = last_addr_q;
        try_cnt_d    = try_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        word_d       = word_q;
        mask_d       = mask_q;
        word_valid_d = word_valid_q;
        wins_d       = wins_q;
        losses_d     = losses_q;

        case (state_q)
            S_IDLE: begin
                if (!auto_mode) begin
                    addr_d = sw_select;
                end
                if (start) begin
                    addr_d       = auto_mode ? (last_addr_q + 4'd1) : sw_select;
                    try_cnt_d    = 4'd0;
                    lat_cnt_d    = 3'd0;
                    word_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end
            end

            S_FETCH: begin
                if (abort) begin
                    word_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (lat_cnt_q == LAT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end

            S_CHECK: begin
                if (abort) begin
                    word_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (ram_q[25:0] != 26'd0) begin
                    word_d       = ram_q[55:26];
                    mask_d       = ram_q[25:0];
                    word_valid_d = 1'b1;
                    last_addr_d  = addr_q;
                    state_d      = S_ARM;
                end else if (!auto_mode || try_cnt_q == 4'd15) begin
                    state_d = S_EMPTY;
                end else begin
                    // An empty entry in auto mode moves the scan on to the next slot.
                    // The 4-bit address wraps from 15 to 0 on its own.
                    try_cnt_d = try_cnt_q + 4'd1;
                    addr_d    = addr_q + 4'd1;
                    lat_cnt_d = 3'd0;
                    state_d   = S_FETCH;
                end
            end

            S_ARM: begin
                if (abort) begin
                    word_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_PLAY;
                end
            end

            S_PLAY: begin
                // abort comes first, so a result in the same cycle is dropped.
                if (abort) begin
                    word_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (game_state == 2'd2) begin
                    if (wins_q != 4'd15) begin
                        wins_d = wins_q + 4'd1;
                    end
                    hold_cnt_d = 27'd0;
                    state_d    = S_HOLD;
                end else if (game_state == 2'd3) begin
                    if (losses_q != 4'd15) begin
                        losses_d = losses_q + 4'd1;
                    end
                    hold_cnt_d = 27'd0;
                    state_d    = S_HOLD;
                end
            end

            S_HOLD: begin
                if (abort) begin
                    word_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 27'd1;
                end
            end

            S_EMPTY: begin
                if (start || abort) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flags are decoded from the next state so they register on the entry edge.
        game_start_d = (state_d == S_ARM);
        busy_d       = (state_d != S_IDLE) && (state_d != S_EMPTY);
        error_d      = (state_d == S_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= 4'd0;
            last_addr_q  <= 4'd15;
            try_cnt_q    <= 4'd0;
            lat_cnt_q    <= 3'd0;
            hold_cnt_q   <= 27'd0;
            word_q       <= 30'd0;
            mask_q       <= 26'd0;
            word_valid_q <= 1'b0;
            game_start_q <= 1'b0;
            wins_q       <= 4'd0;
            losses_q     <= 4'd0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_addr_q  <= last_addr_d;
            try_cnt_q    <= try_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            word_q       <= word_d;
            mask_q       <= mask_d;
            word_valid_q <= word_valid_d;
            game_start_q <= game_start_d;
            wins_q       <= wins_d;
            losses_q     <= losses_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign ram_address = addr_q;
    assign word        = word_q;
    assign mask        = mask_q;
    assign word_valid  = word_valid_q;
    assign game_start  = game_start_q;
    assign wins        = wins_q;
    assign losses      = losses_q;
    assign round_state = state_q;
    assign busy        = busy_q;
    assign error       = error_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with RAM_LATENCY=2, HOLD_CYCLES=4.
// A small word_ram model gives ram_q two cycles after each ram_address change.

module tb_round_controller;

    localparam int L = 2;
    localparam int H = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_ARM   = 3'd3;
    localparam logic [2:0] ST_PLAY  = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;
    localparam logic [2:0] ST_EMPTY = 3'd6;

    localparam logic [29:0] W5 = 30'h0123_4567;
    localparam logic [25:0] M5 = 26'h00A_BCDE;
    localparam logic [29:0] W2 = 30'h2AAA_5555;
    localparam logic [25:0] M2 = 26'h155_5555;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, abort = 1'b0, auto_mode = 1'b0;
    logic [3:0]  sw_select = 4'd0;
    logic [1:0]  game_state = 2'd0;
    logic [3:0]  ram_address;
    logic [55:0] ram_q;
    logic [29:0] word;
    logic [25:0] mask;
    logic        word_valid, game_start, busy, error;
    logic [3:0]  wins, losses;
    logic [2:0]  round_state;

    int checks = 0;
    int errors = 0;
    logic seen_gs;

    round_controller #(.RAM_LATENCY(L), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .auto_mode(auto_mode), .sw_select(sw_select),
        .ram_address(ram_address), .ram_q(ram_q),
        .word(word), .mask(mask), .word_valid(word_valid),
        .game_start(game_start), .game_state(game_state),
        .wins(wins), .losses(losses), .round_state(round_state),
        .busy(busy), .error(error)
    );

    // word_ram model: the address passes through two registers.
    logic [55:0] mem [16];
    logic [3:0]  p0 = 4'd0, p1 = 4'd0;
    always @(posedge clk) begin
        p0 <= ram_address;
        p1 <= p0;
    end
    assign ram_q = mem[p1];

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 56'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        clear_mem();
        mem[5] = {W5, M5};

        // reset state
        step(); step();
        chk("rst_state", round_state, ST_IDLE);
        chk("rst_addr", ram_address, 0);
        chk("rst_wins", wins, 0);
        chk("rst_losses", losses, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_gs", game_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", error, 0);
        reset = 1'b0;

        // manual round, win
        sw_select = 4'd5;
        step();
        chk("man_follow", ram_address, 5);
        pulse_start();                                   // T+1
        chk("man_t1_state", round_state, ST_FETCH);
        chk("man_t1_busy", busy, 1);
        chk("man_t1_addr", ram_address, 5);
        step();                                          // T+2
        chk("man_t2_state", round_state, ST_FETCH);
        chk("man_t2_gs", game_start, 0);
        step();                                          // T+3
        chk("man_t3_state", round_state, ST_CHECK);
        chk("man_t3_gs", game_start, 0);
        step();                                          // T+4
        chk("man_t4_state", round_state, ST_ARM);
        chk("man_t4_gs", game_start, 1);
        chk("man_t4_word", word, W5);
        chk("man_t4_mask", mask, M5);
        chk("man_t4_valid", word_valid, 1);
        pulse_start();                                   // T+5, start ignored
        chk("man_t5_state", round_state, ST_PLAY);
        chk("man_t5_gs", game_start, 0);
        step();                                          // T+6
        chk("man_t6_state", round_state, ST_PLAY);
        game_state = 2'd2;
        step();                                          // T+7
        game_state = 2'd0;
        chk("man_t7_state", round_state, ST_HOLD);
        chk("man_t7_wins", wins, 1);
        for (int k = 8; k <= 10; k++) begin
            step();
            chk("man_hold_state", round_state, ST_HOLD);
            chk("man_hold_valid", word_valid, 1);
        end
        step();                                          // T+11
        chk("man_t11_state", round_state, ST_IDLE);
        chk("man_t11_busy", busy, 0);
        chk("man_t11_valid", word_valid, 1);

        // abort racing a loss in PLAY
        pulse_start();
        repeat (4) step();
        chk("race_play", round_state, ST_PLAY);
        abort = 1'b1;
        game_state = 2'd3;
        step();
        abort = 1'b0;
        game_state = 2'd0;
        chk("race_state", round_state, ST_IDLE);
        chk("race_losses", losses, 0);
        chk("race_wins", wins, 1);
        chk("race_valid", word_valid, 0);

        // synchronous reset during FETCH
        pulse_start();
        chk("rmid_fetch", round_state, ST_FETCH);
        auto_mode = 1'b1;
        reset = 1'b1;
        step();
        chk("rmid_state", round_state, ST_IDLE);
        chk("rmid_addr", ram_address, 0);
        chk("rmid_wins", wins, 0);
        chk("rmid_word", word, 0);
        chk("rmid_mask", mask, 0);
        chk("rmid_valid", word_valid, 0);
        chk("rmid_busy", busy, 0);
        reset = 1'b0;
        step();

        // auto scan: entries 0 and 1 empty, entry 2 valid
        mem[2] = {W2, M2};
        pulse_start();                                   // T+1
        chk("auto_t1_addr", ram_address, 0);
        seen_gs = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            step();
            if (game_start) seen_gs = 1'b1;
            if (k == 3) chk("auto_t3_state", round_state, ST_CHECK);
            if (k == 4) chk("auto_t4_addr", ram_address, 1);
            if (k == 7) chk("auto_t7_addr", ram_address, 2);
        end
        chk("auto_early_gs", seen_gs, 0);
        step();                                          // T+10
        chk("auto_t10_state", round_state, ST_ARM);
        chk("auto_t10_gs", game_start, 1);
        chk("auto_t10_word", word, W2);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("auto_abort", round_state, ST_IDLE);
        pulse_start();
        chk("auto_next_addr", ram_address, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("auto_next_abort", round_state, ST_IDLE);

        // loss saturation with manual rounds on entry 5
        auto_mode = 1'b0;
        sw_select = 4'd5;
        step();
        for (int r = 0; r < 17; r++) begin
            pulse_start();
            repeat (4) step();
            game_state = 2'd3;
            step();
            game_state = 2'd0;
            chk("sat_hold", round_state, ST_HOLD);
            chk("sat_losses", losses, (r < 15) ? r + 1 : 15);
            repeat (4) step();
            chk("sat_idle", round_state, ST_IDLE);
        end
        chk("sat_wins", wins, 0);

        // every entry empty
        clear_mem();
        auto_mode = 1'b1;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort", round_state, ST_IDLE);
        pulse_start();                                   // T+1
        seen_gs = 1'b0;
        for (int k = 2; k <= 48; k++) begin
            step();
            if (game_start) seen_gs = 1'b1;
        end
        chk("empty_t48_state", round_state, ST_CHECK);
        chk("empty_t48_err", error, 0);
        step();                                          // T+49
        chk("empty_state", round_state, ST_EMPTY);
        chk("empty_err", error, 1);
        chk("empty_busy", busy, 0);
        chk("empty_no_gs", seen_gs, 0);
        step();
        chk("empty_stay", round_state, ST_EMPTY);
        pulse_start();
        chk("empty_exit_state", round_state, ST_IDLE);
        chk("empty_exit_err", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
